control_encoder: RTL and testbench

- Inverse of the opcode-to-control-signal decoder. Takes a bundle of the eight datapath control signals, encodes it back into its 4-bit opcode, and buffers the opcodes in a small FIFO.
- Used by the trace/checker path so that the control signals the datapath applied can be replayed as an opcode stream.
- Bundles that match no opcode are dropped and counted.
- Valid/ready handshake on both sides.

---
 rtl/control_encoder_if.sv | 27 ++
 rtl/control_encoder.sv | 91 +++++++++
 tb/tb_control_encoder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/control_encoder_if.sv
// Handshake bundle between a control-signal producer, the encoder FIFO and the opcode consumer.
interface control_encoder_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       ctrl_in;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_opcode;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] illegal_cnt;
  logic             illegal_seen;

  modport master (
    output in_valid, ctrl_in, out_ready,
    input  in_ready, out_valid, out_opcode, level, illegal_cnt, illegal_seen
  );

  modport slave (
    input  in_valid, ctrl_in, out_ready,
    output in_ready, out_valid, out_opcode, level, illegal_cnt, illegal_seen
  );
endinterface

// File: rtl/control_encoder.sv
// Encodes a datapath control bundle back to its 4-bit opcode and queues opcodes in a small FIFO;
// bundles matching no opcode are dropped and counted.
module control_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  control_encoder_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [3:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_q, seen_d;

  logic       legal;
  logic [3:0] enc_op;
  logic       in_ready_w, out_valid_w;
  logic       accept, push, pop, drop;

  always_comb begin
    legal  = 1'b1;
    enc_op = '0;
    case (bus.ctrl_in)
      8'b0010_0100: enc_op = 4'b0000;
      8'b0011_0100: enc_op = 4'b0001;
      8'b0010_1000: enc_op = 4'b0010;
      8'b0011_1000: enc_op = 4'b0011;
      8'b1010_0000: enc_op = 4'b0100;
      8'b0100_0000: enc_op = 4'b0101;
      8'b0000_0010: enc_op = 4'b0110;
      8'b0000_0001: enc_op = 4'b0111;
      default:      legal  = 1'b0;
    endcase
  end

  // Ready depends on registered occupancy only, so a pop never frees a slot in the same cycle.
  always_comb begin
    in_ready_w  = (level_q < LW'(DEPTH));
    out_valid_w = (level_q != '0);
    accept      = bus.in_valid && in_ready_w;
    push        = accept && legal;
    drop        = accept && !legal;
    pop         = out_valid_w && bus.out_ready;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    cnt_d  = (drop && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    seen_d = seen_q | drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      seen_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= enc_op;
  end

  assign bus.in_ready     = in_ready_w;
  assign bus.out_valid    = out_valid_w;
  assign bus.out_opcode   = out_valid_w ? mem_q[rd_ptr_q] : 4'b0000;
  assign bus.level        = level_q;
  assign bus.illegal_cnt  = cnt_q;
  assign bus.illegal_seen = seen_q;
endmodule

// File: tb/tb_control_encoder.sv
// Bench for control_encoder: constant vector table, directed corner sequences and random traffic
// checked against a queue-based opcode model.
module tb_control_encoder;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    logic [7:0] ctrl;
    bit         legal;
    logic [3:0] op;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  control_encoder_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus_a ();
  control_encoder_if #(.DEPTH(DEPTH), .CNT_W(2))     bus_b ();

  control_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  control_encoder #(.DEPTH(DEPTH), .CNT_W(2)) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  logic [7:0]  legal_tab [8];
  logic [3:0]  mq [$];
  int unsigned m_cnt;
  bit          m_seen;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit lookup(input logic [7:0] c, output logic [3:0] op);
    op = 4'b0000;
    for (int unsigned i = 0; i < 8; i++) begin
      if (legal_tab[i] == c) begin
        op = 4'(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_step(input bit v, input logic [7:0] c, input bit r, input bit rs);
    bit         rdy, lg;
    logic [3:0] op;
    if (rs) begin
      mq.delete();
      m_cnt  = 0;
      m_seen = 1'b0;
      return;
    end
    rdy = (mq.size() < DEPTH);
    lg  = lookup(c, op);
    if (mq.size() != 0 && r) void'(mq.pop_front());
    if (v && rdy) begin
      if (lg) mq.push_back(op);
      else begin
        if (m_cnt < CMAX) m_cnt++;
        m_seen = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    check("level",        32'(bus_a.level),        32'(mq.size()));
    check("in_ready",     32'(bus_a.in_ready),     32'(mq.size() < DEPTH));
    check("out_valid",    32'(bus_a.out_valid),    32'(mq.size() != 0));
    check("out_opcode",   32'(bus_a.out_opcode),   (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    check("illegal_cnt",  32'(bus_a.illegal_cnt),  32'(m_cnt));
    check("illegal_seen", 32'(bus_a.illegal_seen), 32'(m_seen));
  endtask

  task automatic cycle(input bit v, input logic [7:0] c, input bit r, input bit rs);
    bus_a.in_valid  = v;
    bus_a.ctrl_in   = c;
    bus_a.out_ready = r;
    rst             = rs;
    @(posedge clk);
    model_step(v, c, r, rs);
    #1;
    check_model();
  endtask

  task automatic drain();
    for (int unsigned k = 0; k < 2 * DEPTH; k++) begin
      if (mq.size() != 0) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  initial begin
    vec_t       vecs [12];
    int unsigned exp_cnt;
    int unsigned deliv;
    int unsigned sat_exp [5];

    legal_tab = '{8'h24, 8'h34, 8'h28, 8'h38, 8'hA0, 8'h40, 8'h02, 8'h01};
    vecs[0]  = '{8'h24, 1'b1, 4'h0};
    vecs[1]  = '{8'h34, 1'b1, 4'h1};
    vecs[2]  = '{8'h28, 1'b1, 4'h2};
    vecs[3]  = '{8'h38, 1'b1, 4'h3};
    vecs[4]  = '{8'hA0, 1'b1, 4'h4};
    vecs[5]  = '{8'h40, 1'b1, 4'h5};
    vecs[6]  = '{8'h02, 1'b1, 4'h6};
    vecs[7]  = '{8'h01, 1'b1, 4'h7};
    vecs[8]  = '{8'hFF, 1'b0, 4'h0};
    vecs[9]  = '{8'h00, 1'b0, 4'h0};
    vecs[10] = '{8'h25, 1'b0, 4'h0};
    vecs[11] = '{8'h0C, 1'b0, 4'h0};
    sat_exp  = '{1, 2, 3, 3, 3};

    bus_b.in_valid  = 1'b0;
    bus_b.ctrl_in   = 8'h00;
    bus_b.out_ready = 1'b0;

    // reset state
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("rst_level",    32'(bus_a.level), 0);
    check("rst_in_ready", 32'(bus_a.in_ready), 1);
    check("rst_out_op",   32'(bus_a.out_opcode), 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // table vectors, back to back with out_ready=1
    exp_cnt = 0;
    for (int unsigned i = 0; i < 12; i++) begin
      cycle(1'b1, vecs[i].ctrl, 1'b1, 1'b0);
      if (!vecs[i].legal) exp_cnt++;
      check("vec_valid", 32'(bus_a.out_valid), 32'(vecs[i].legal));
      check("vec_level", 32'(bus_a.level),     32'(vecs[i].legal));
      check("vec_cnt",   32'(bus_a.illegal_cnt), 32'(exp_cnt));
      if (vecs[i].legal) check("vec_op", 32'(bus_a.out_opcode), 32'(vecs[i].op));
    end
    drain();

    // backpressure: 5 adds with out_ready=0
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int unsigned k = 0; k < 5; k++) begin
      cycle(1'b1, 8'h24, 1'b0, 1'b0);
      if (k >= 3) begin
        check("bp_level", 32'(bus_a.level), 4);
        check("bp_ready", 32'(bus_a.in_ready), 0);
      end
    end
    check("bp_head", 32'(bus_a.out_opcode), 0);
    deliv = 1;
    cycle(1'b1, 8'h24, 1'b1, 1'b0);
    check("bp_pop_noaccept", 32'(bus_a.level), 3);
    cycle(1'b1, 8'h24, 1'b0, 1'b0);
    check("bp_fifth_in", 32'(bus_a.level), 4);
    for (int unsigned k = 0; k < 8; k++) begin
      if (bus_a.out_valid) begin
        check("bp_op", 32'(bus_a.out_opcode), 0);
        deliv++;
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
      end
    end
    check("bp_delivered", deliv, 5);

    // illegal drop: FF, 00, 24
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    cycle(1'b1, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h24, 1'b0, 1'b0);
    check("ill_cnt",   32'(bus_a.illegal_cnt), 2);
    check("ill_seen",  32'(bus_a.illegal_seen), 1);
    check("ill_level", 32'(bus_a.level), 1);
    check("ill_op",    32'(bus_a.out_opcode), 0);
    drain();

    // saturation on the 2-bit counter instance
    for (int unsigned k = 0; k < 5; k++) begin
      bus_b.in_valid = 1'b1;
      bus_b.ctrl_in  = 8'hFF;
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      check("sat_cnt", 32'(bus_b.illegal_cnt), sat_exp[k]);
    end
    check("sat_seen",  32'(bus_b.illegal_seen), 1);
    check("sat_level", 32'(bus_b.level), 0);
    bus_b.in_valid = 1'b0;

    // simultaneous push and pop at level 2
    cycle(1'b1, 8'h24, 1'b0, 1'b0);
    cycle(1'b1, 8'h38, 1'b0, 1'b0);
    cycle(1'b1, 8'h40, 1'b1, 1'b0);
    check("pp_level", 32'(bus_a.level), 2);
    check("pp_head",  32'(bus_a.out_opcode), 3);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("pp_tail",  32'(bus_a.out_opcode), 5);
    drain();

    // reset mid-stream with a bundle presented
    for (int unsigned k = 0; k < 3; k++) cycle(1'b1, 8'h02, 1'b0, 1'b0);
    check("mr_fill", 32'(bus_a.level), 3);
    cycle(1'b1, 8'h24, 1'b0, 1'b1);
    check("mr_level", 32'(bus_a.level), 0);
    check("mr_valid", 32'(bus_a.out_valid), 0);
    check("mr_op",    32'(bus_a.out_opcode), 0);
    check("mr_cnt",   32'(bus_a.illegal_cnt), 0);
    check("mr_seen",  32'(bus_a.illegal_seen), 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("mr_after", 32'(bus_a.level), 0);

    // random traffic against the model
    for (int unsigned n = 0; n < 600; n++) begin
      logic [7:0] c;
      c = ($urandom_range(0, 1) == 1) ? legal_tab[$urandom_range(0, 7)] : 8'($urandom);
      cycle(1'($urandom_range(0, 1)), c, ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 99) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
